wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Writeback stage merged with the architectural register file. Consumes the MEM/WB buffer outputs,
//  selects the port-1 writeback value (memory data or ALU result) and commits up to two register
//  writes per cycle. Serves two asynchronous read ports to the decode stage and exports the committed
//  writeback bundle to the forwarding unit.
// PARAMETERS
//  DATA_W   16  register / data width
//  ADDR_W    3  register index width
//  NREGS     8  register count (must equal 2**ADDR_W)
// PORTS
//  clk          in   1       write clock; commits on posedge (MEM/WB launches on negedge)
//  reset        in   1       asynchronous, active-high; clears every register
//  rdst1_in     in   ADDR_W  port-1 destination index
//  rdst1_val_in in   DATA_W  port-1 ALU result
//  data_in      in   DATA_W  memory read data
//  memtoreg_in  in   1       1: port-1 value = data_in, 0: port-1 value = rdst1_val_in
//  reglow_we    in   1       port-1 write enable
//  rdst2_in     in   ADDR_W  port-2 destination index (SWAP / second result)
//  rdst2_val_in in   DATA_W  port-2 value
//  reghigh_we   in   1       port-2 write enable
//  rs1_addr     in   ADDR_W  decode read port A index
//  rs2_addr     in   ADDR_W  decode read port B index
//  rs1_data     out  DATA_W  read port A data
//  rs2_data     out  DATA_W  read port B data
//  wb1_val      out  DATA_W  selected port-1 writeback value (to forwarding unit)
//  wb1_dst      out  ADDR_W  = rdst1_in
//  wb1_we       out  1       = reglow_we
//  wb2_val/dst/we out DATA_W/ADDR_W/1  = rdst2_val_in / rdst2_in / reghigh_we
//  wr_count     out  16      committed register-write counter (debug / perf)
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-cycle): regs[0..NREGS-1]=0, wr_count=0; rs*_data read 0 until
//    first write; wb* outputs are combinational pass-throughs of the inputs (no reset state).
//  - wb1_val = memtoreg_in ? data_in : rdst1_val_in (combinational, 0-cycle).
//  - posedge clk, reset low: if reglow_we regs[rdst1_in]<=wb1_val; if reghigh_we regs[rdst2_in]<=rdst2_val_in.
//  - Both enables, rdst1_in==rdst2_in: port 1 wins; only wb1_val is stored; counts as one write.
//  - wr_count += (#distinct registers written that edge: 0,1,2); wraps 16'hFFFF -> 0.
//  - No register is hard-wired; index 0 is an ordinary register.
//  - Reads: rs*_data = regs[rs*_addr], combinational; new value visible after the posedge that writes it.
//  - Enables low: no array change regardless of index/data values (including X on data).
//  - MEM/WB flush arrives as all-zero inputs: enables 0 -> no write.
// CONFIGURATION
//  WB_BYPASS_EN defined: read ports are write-through. If a read index matches an enabled write
//    index this cycle, rs*_data returns the pending write value (port-1 priority on double match)
//    before the posedge; decode needs no WB-stage forwarding.
//  WB_BYPASS_EN undefined: rs*_data always returns stored array contents; pending writes invisible
//    until after the posedge.
// TESTING
//  1 Reset: assert reset mid-run after writing R3=16'h1234 -> rs1_addr=3 reads 0, wr_count=0 immediately.
//  2 memToReg mux: rdst1=2, rdst1_val=16'h00AA, data=16'h5555, memtoreg=1, reglow_we=1 -> R2=16'h5555;
//    repeat memtoreg=0 -> R2=16'h00AA; wr_count=2.
//  3 Dual write (SWAP): rdst1=1 val 16'hBEEF, rdst2=4 val 16'hCAFE, both we -> R1=BEEF, R4=CAFE, wr_count +2.
//  4 Conflict: rdst1=rdst2=5, vals 16'h1111/16'h2222, both we -> R5=16'h1111, wr_count +1.
//  5 Bypass: R6=0, write R6=16'h7777 with rs2_addr=6 -> before posedge rs2_data=7777 with WB_BYPASS_EN,
//    0 without; after posedge 7777 in both builds.
//  6 Hold/wrap: enables 0 with random data 100 cycles -> array unchanged; preload wr_count=16'hFFFF
//    via 65535 writes, one more write -> wr_count=0.

Source files
------------

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile -- writeback stage merged with the architectural register file.
//
// Selects the port-1 writeback value (memory data or ALU result), commits up
// to two register writes per posedge, serves two combinational read ports to
// decode and passes the committed writeback bundle on to the forwarding unit.
//
// Ports
//   clk, reset                  write clock, async active-high reset
//   rdst1_in / rdst1_val_in     port-1 destination / ALU result
//   data_in, memtoreg_in        memory data and port-1 value select
//   reglow_we                   port-1 write enable
//   rdst2_in / rdst2_val_in     port-2 destination / value
//   reghigh_we                  port-2 write enable
//   rs1_addr/rs1_data           read port A
//   rs2_addr/rs2_data           read port B
//   wb1_val/dst/we, wb2_*       writeback bundle to the forwarding unit
//   wr_count                    committed register-write counter (wraps)
//
// Configuration
//   WB_BYPASS_EN  when defined, read ports are write-through: a read index
//                 matching an enabled write this cycle returns the pending
//                 value (port 1 has priority). Undefined: reads return the
//                 stored array contents only.
//
// NREGS must equal 2**ADDR_W so every index decodes to a real register.
// ---------------------------------------------------------------------------

// One architectural register.
module wb_regfile_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (we) q <= d;
    end
endmodule

module wb_regfile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rdst1_in,
    input  logic [DATA_W-1:0] rdst1_val_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              memtoreg_in,
    input  logic              reglow_we,
    input  logic [ADDR_W-1:0] rdst2_in,
    input  logic [DATA_W-1:0] rdst2_val_in,
    input  logic              reghigh_we,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] wb1_val,
    output logic [ADDR_W-1:0] wb1_dst,
    output logic              wb1_we,
    output logic [DATA_W-1:0] wb2_val,
    output logic [ADDR_W-1:0] wb2_dst,
    output logic              wb2_we,
    output logic [15:0]       wr_count
);
    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic                         we2_eff;
    logic [1:0]                   wr_inc;

    assign wb1_val = memtoreg_in ? data_in : rdst1_val_in;
    assign wb1_dst = rdst1_in;
    assign wb1_we  = reglow_we;
    assign wb2_val = rdst2_val_in;
    assign wb2_dst = rdst2_in;
    assign wb2_we  = reghigh_we;

    // Port 2 is suppressed when port 1 targets the same register: port 1
    // wins and the edge counts as a single write.
    assign we2_eff = reghigh_we & ~(reglow_we & (rdst1_in == rdst2_in));

    genvar g;
    generate
        for (g = 0; g < NREGS; g++) begin : g_reg
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(g);
            logic sel1, sel2;
            assign sel1 = reglow_we & (rdst1_in == IDX);
            assign sel2 = we2_eff   & (rdst2_in == IDX);
            wb_regfile_reg #(.DATA_W(DATA_W)) u_reg (
                .clk   (clk),
                .reset (reset),
                .we    (sel1 | sel2),
                .d     (sel1 ? wb1_val : rdst2_val_in),
                .q     (regs[g])
            );
        end
    endgenerate

    assign wr_inc = {1'b0, reglow_we} + {1'b0, we2_eff};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_count <= '0;
        else       wr_count <= wr_count + {14'b0, wr_inc};
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        rs1_data = regs[rs1_addr];
        if (reglow_we && rdst1_in == rs1_addr)     rs1_data = wb1_val;
        else if (we2_eff && rdst2_in == rs1_addr)  rs1_data = rdst2_val_in;
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (reglow_we && rdst1_in == rs2_addr)     rs2_data = wb1_val;
        else if (we2_eff && rdst2_in == rs2_addr)  rs2_data = rdst2_val_in;
    end
`else
    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];
`endif

endmodule

// File: tb/tb_wb_regfile.sv
`timescale 1ns/100ps
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  rdst1_in, rdst2_in, rs1_addr, rs2_addr, wb1_dst, wb2_dst;
    logic [15:0] rdst1_val_in, data_in, rdst2_val_in;
    logic        memtoreg_in, reglow_we, reghigh_we, wb1_we, wb2_we;
    logic [15:0] rs1_data, rs2_data, wb1_val, wb2_val, wr_count;

    wb_regfile dut (
        .clk(clk), .reset(reset),
        .rdst1_in(rdst1_in), .rdst1_val_in(rdst1_val_in), .data_in(data_in),
        .memtoreg_in(memtoreg_in), .reglow_we(reglow_we),
        .rdst2_in(rdst2_in), .rdst2_val_in(rdst2_val_in), .reghigh_we(reghigh_we),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb1_val(wb1_val), .wb1_dst(wb1_dst), .wb1_we(wb1_we),
        .wb2_val(wb2_val), .wb2_dst(wb2_dst), .wb2_we(wb2_we),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Reference model: plain array of register values and a write tally.
    logic [15:0] m_regs [8];
    logic [15:0] m_cnt;
    int n_vec = 0;
    int n_err = 0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached (got no finish, need finish)");
        $fatal(1);
    end

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_cnt = 16'h0;
    endfunction

    // Apply the architectural effect of the currently driven inputs.
    function automatic void model_commit();
        logic [15:0] v1;
        int          nw;
        v1 = memtoreg_in ? data_in : rdst1_val_in;
        nw = 0;
        if (reghigh_we) begin
            m_regs[rdst2_in] = rdst2_val_in;
            nw = nw + 1;
        end
        if (reglow_we) begin
            m_regs[rdst1_in] = v1;
            if (!(reghigh_we && rdst1_in == rdst2_in)) nw = nw + 1;
        end
        m_cnt = m_cnt + 16'(nw);
    endfunction

    // Expected read value before the edge for the currently driven inputs.
    function automatic logic [15:0] exp_rd(input logic [2:0] a);
`ifdef WB_BYPASS_EN
        if (reglow_we && rdst1_in == a) return memtoreg_in ? data_in : rdst1_val_in;
        if (reghigh_we && rdst2_in == a) return rdst2_val_in;
`endif
        return m_regs[a];
    endfunction

    task automatic idle();
        reglow_we = 1'b0; reghigh_we = 1'b0; memtoreg_in = 1'b0;
        rdst1_in = '0; rdst2_in = '0; rdst1_val_in = '0; rdst2_val_in = '0; data_in = '0;
    endtask

    // Drive one MEM/WB beat on the negedge, let it commit on the posedge.
    task automatic commit(input logic [2:0] d1, input logic [15:0] a1, input logic [15:0] dat,
                          input logic mtr, input logic we1,
                          input logic [2:0] d2, input logic [15:0] v2, input logic we2);
        @(negedge clk);
        rdst1_in = d1; rdst1_val_in = a1; data_in = dat; memtoreg_in = mtr; reglow_we = we1;
        rdst2_in = d2; rdst2_val_in = v2; reghigh_we = we2;
        @(posedge clk);
        model_commit();
        #1;
        idle();
    endtask

    task automatic check_all(input string name);
        idle();
        for (int i = 0; i < 8; i++) begin
            rs1_addr = 3'(i);
            rs2_addr = 3'(i) ^ 3'd3;
            #1;
            n_vec++;
            if (rs1_data !== m_regs[rs1_addr]) begin
                n_err++;
                $display("FAIL %s rs1[%0d]: got %h want %h", name, rs1_addr, rs1_data, m_regs[rs1_addr]);
            end
            n_vec++;
            if (rs2_data !== m_regs[rs2_addr]) begin
                n_err++;
                $display("FAIL %s rs2[%0d]: got %h want %h", name, rs2_addr, rs2_data, m_regs[rs2_addr]);
            end
        end
        n_vec++;
        if (wr_count !== m_cnt) begin
            n_err++;
            $display("FAIL %s wr_count: got %h want %h", name, wr_count, m_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        rs1_addr = '0; rs2_addr = '0;
        model_clear();
        #12;
        check_all("reset_initial");
        @(negedge clk) reset = 1'b0;
        commit(3'd3, 16'h1234, 16'h0, 1'b0, 1'b1, 3'd0, 16'h0, 1'b0);
        check_all("reset_prewrite");
        // Mid-cycle async reset must clear immediately.
        @(posedge clk);
        #3;
        rs1_addr = 3'd3;
        reset = 1'b1;
        model_clear();
        #1;
        n_vec++;
        if (rs1_data !== 16'h0) begin
            n_err++;
            $display("FAIL reset_mid rs1[3]: got %h want 0000", rs1_data);
        end
        n_vec++;
        if (wr_count !== 16'h0) begin
            n_err++;
            $display("FAIL reset_mid wr_count: got %h want 0000", wr_count);
        end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_memtoreg();
        commit(3'd2, 16'h00AA, 16'h5555, 1'b1, 1'b1, 3'd0, 16'h0, 1'b0);
        check_all("memtoreg_1");
        commit(3'd2, 16'h00AA, 16'h5555, 1'b0, 1'b1, 3'd0, 16'h0, 1'b0);
        check_all("memtoreg_0");
        n_vec++;
        if (wr_count !== 16'd2) begin
            n_err++;
            $display("FAIL memtoreg_count: got %h want 0002", wr_count);
        end
    endtask

    task automatic test_swap();
        commit(3'd1, 16'hBEEF, 16'h0, 1'b0, 1'b1, 3'd4, 16'hCAFE, 1'b1);
        check_all("swap");
        n_vec++;
        if (wr_count !== 16'd4) begin
            n_err++;
            $display("FAIL swap_count: got %h want 0004", wr_count);
        end
    endtask

    task automatic test_conflict();
        commit(3'd5, 16'h1111, 16'h0, 1'b0, 1'b1, 3'd5, 16'h2222, 1'b1);
        check_all("conflict");
        rs1_addr = 3'd5;
        #1;
        n_vec++;
        if (rs1_data !== 16'h1111 || wr_count !== 16'd5) begin
            n_err++;
            $display("FAIL conflict_direct: got %h/%h want 1111/0005", rs1_data, wr_count);
        end
    endtask

    task automatic test_bypass();
        logic [15:0] want;
        @(negedge clk);
        rdst1_in = 3'd6; rdst1_val_in = 16'h7777; data_in = 16'h0; memtoreg_in = 1'b0;
        reglow_we = 1'b1; reghigh_we = 1'b0; rs2_addr = 3'd6;
        #1;
`ifdef WB_BYPASS_EN
        want = 16'h7777;
`else
        want = 16'h0000;
`endif
        n_vec++;
        if (rs2_data !== want) begin
            n_err++;
            $display("FAIL bypass_pre rs2: got %h want %h", rs2_data, want);
        end
        @(posedge clk);
        model_commit();
        #1;
        n_vec++;
        if (rs2_data !== 16'h7777) begin
            n_err++;
            $display("FAIL bypass_post rs2: got %h want 7777", rs2_data);
        end
        idle();
    endtask

    task automatic test_hold();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            rdst1_in = 3'($urandom); rdst2_in = 3'($urandom);
            rdst1_val_in = 16'($urandom); rdst2_val_in = 16'($urandom); data_in = 16'($urandom);
            memtoreg_in = 1'($urandom); reglow_we = 1'b0; reghigh_we = 1'b0;
            rs1_addr = 3'($urandom); rs2_addr = 3'($urandom);
            #1;
            n_vec++;
            if (rs1_data !== m_regs[rs1_addr] || rs2_data !== m_regs[rs2_addr]) begin
                n_err++;
                $display("FAIL hold cyc %0d: got %h/%h want %h/%h", c, rs1_data, rs2_data,
                         m_regs[rs1_addr], m_regs[rs2_addr]);
            end
            @(posedge clk);
            model_commit();
        end
        #1;
        check_all("hold_end");
    endtask

    task automatic test_random();
        logic [15:0] e1, e2, ev;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            rdst1_in = 3'($urandom); rdst2_in = ($urandom_range(0, 3) == 0) ? rdst1_in : 3'($urandom);
            rdst1_val_in = 16'($urandom); rdst2_val_in = 16'($urandom); data_in = 16'($urandom);
            memtoreg_in = 1'($urandom); reglow_we = 1'($urandom); reghigh_we = 1'($urandom);
            rs1_addr = 3'($urandom); rs2_addr = ($urandom_range(0, 1) == 0) ? rdst2_in : 3'($urandom);
            #1;
            e1 = exp_rd(rs1_addr);
            e2 = exp_rd(rs2_addr);
            ev = memtoreg_in ? data_in : rdst1_val_in;
            n_vec++;
            if (rs1_data !== e1 || rs2_data !== e2) begin
                n_err++;
                $display("FAIL random_read cyc %0d: got %h/%h want %h/%h", c, rs1_data, rs2_data, e1, e2);
            end
            n_vec++;
            if (wb1_val !== ev || wb1_dst !== rdst1_in || wb1_we !== reglow_we ||
                wb2_val !== rdst2_val_in || wb2_dst !== rdst2_in || wb2_we !== reghigh_we) begin
                n_err++;
                $display("FAIL random_wb cyc %0d: got %h/%0d/%b %h/%0d/%b want %h/%0d/%b %h/%0d/%b", c,
                         wb1_val, wb1_dst, wb1_we, wb2_val, wb2_dst, wb2_we,
                         ev, rdst1_in, reglow_we, rdst2_val_in, rdst2_in, reghigh_we);
            end
            @(posedge clk);
            model_commit();
            #1;
            n_vec++;
            if (wr_count !== m_cnt) begin
                n_err++;
                $display("FAIL random_count cyc %0d: got %h want %h", c, wr_count, m_cnt);
            end
        end
        check_all("random_end");
    endtask

    task automatic test_wrap();
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        #1 reset = 1'b0;
        // 32767 dual writes + 1 single write bring the counter to 16'hFFFF.
        @(negedge clk);
        rdst1_in = 3'd0; rdst2_in = 3'd7; rdst1_val_in = 16'hA5A5; rdst2_val_in = 16'h5A5A;
        memtoreg_in = 1'b0; reglow_we = 1'b1; reghigh_we = 1'b1;
        for (int c = 0; c < 32767; c++) begin
            @(posedge clk);
            model_commit();
        end
        @(negedge clk);
        reghigh_we = 1'b0;
        @(posedge clk);
        model_commit();
        #1;
        n_vec++;
        if (wr_count !== 16'hFFFF || m_cnt !== 16'hFFFF) begin
            n_err++;
            $display("FAIL wrap_preload: got %h want ffff", wr_count);
        end
        commit(3'd0, 16'h0001, 16'h0, 1'b0, 1'b1, 3'd0, 16'h0, 1'b0);
        n_vec++;
        if (wr_count !== 16'h0000) begin
            n_err++;
            $display("FAIL wrap_rollover: got %h want 0000", wr_count);
        end
        check_all("wrap_end");
    endtask

    initial begin
        test_reset();
        test_memtoreg();
        test_swap();
        test_conflict();
        test_bypass();
        test_hold();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
